// File: rtl/dmem_port_adapter_pkg.sv
// rtl/dmem_port_adapter_pkg.sv - memory function/type encodings and adapter FSM states
package dmem_port_adapter_pkg;

    typedef enum logic [1:0] {
        M_X   = 2'd0,
        M_XRD = 2'd1,
        M_XWR = 2'd2
    } t_m;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5,
        MT_WU = 3'd6
    } t_mt;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } t_dmem_state;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store replication, misalign check and load extension
module dmem_lane_align
    import dmem_port_adapter_pkg::*;
(
    input  t_mt         req_typ,
    input  logic [1:0]  req_off,
    input  logic [31:0] st_data,
    input  t_mt         ld_typ,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        be       = 4'b1111;
        wdata    = st_data;
        misalign = 1'b0;
        case (req_typ)
            MT_B, MT_BU: begin
                be    = 4'b0001 << req_off;
                wdata = {4{st_data[7:0]}};
            end
            MT_H, MT_HU: begin
                be       = 4'b0011 << req_off;
                wdata    = {2{st_data[15:0]}};
                misalign = req_off[0];
            end
            MT_W, MT_WU: misalign = (req_off != 2'b00);
            default: ;
        endcase
    end

    assign shifted = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_typ)
            MT_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            MT_BU: ld_data = {24'b0, shifted[7:0]};
            MT_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            MT_HU: ld_data = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_port_adapter.sv
// rtl/dmem_port_adapter.sv - single-outstanding dmem request responder onto a byte-enabled word SRAM
module dmem_port_adapter
    import dmem_port_adapter_pkg::*;
#(
    parameter int MEM_AW      = 14,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  t_m                req_fcn,
    input  t_mt               req_typ,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_misalign,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    t_dmem_state       state_q, state_d;
    logic              load_req, capture;
    logic [MEM_AW-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    t_mt               typ_q;
    logic [1:0]        off_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       resp_data_q;
    logic              resp_mis_q;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c, ld_data;
    logic              misalign_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

    dmem_lane_align u_align (
        .req_typ  (req_typ),
        .req_off  (req_addr[1:0]),
        .st_data  (req_data),
        .ld_typ   (typ_q),
        .ld_off   (off_q),
        .rdata    (mem_rdata),
        .be       (be_c),
        .wdata    (wdata_c),
        .misalign (misalign_c),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                if (req_typ == MT_X || misalign_c) begin
                    state_d = RESP;
                end else begin
                    state_d  = ISSUE;
                    load_req = 1'b1;
                end
            end
            ISSUE: if (mem_gnt) state_d = we_q ? RESP : WAIT;
            WAIT: if (cnt_q == '0) begin
                state_d = RESP;
                capture = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers are cleared on acceptance so fences, stores and misaligns return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            typ_q       <= MT_X;
            off_q       <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_mis_q  <= 1'b0;
        end else begin
            if (load_req) begin
                addr_q  <= req_addr[MEM_AW+1:2];
                be_q    <= be_c;
                wdata_q <= wdata_c;
                we_q    <= (req_fcn == M_XWR);
                typ_q   <= req_typ;
                off_q   <= req_addr[1:0];
            end
            if (state_q == IDLE && req_valid) begin
                resp_data_q <= '0;
                resp_mis_q  <= (req_typ != MT_X) && misalign_c;
            end
            if (capture) resp_data_q <= ld_data;
            if (state_q == ISSUE && mem_gnt)
                cnt_q <= CW'(MEM_LATENCY - 1);
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign resp_valid    = (state_q == RESP);
    assign resp_data     = resp_valid ? resp_data_q : '0;
    assign resp_misalign = resp_valid && resp_mis_q;
    assign mem_req       = (state_q == ISSUE);
    assign mem_we        = mem_req && we_q;
    assign mem_be        = be_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_port_adapter.sv
// tb/tb_dmem_port_adapter.sv - directed bench for dmem_port_adapter with a 2-cycle SRAM model
module tb_dmem_port_adapter;
    import dmem_port_adapter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr, req_data;
    t_m          req_fcn;
    t_mt         req_typ;
    logic        resp_valid, resp_misalign;
    logic [31:0] resp_data;
    logic        mem_req, gnt, mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    int          lat, mreq_n;
    logic [31:0] rd, wd0;
    logic        mis, unst, extra, we0;
    logic [3:0]  be0;
    logic [13:0] ad0;

    always #5 clk = ~clk;

    dmem_port_adapter #(.MEM_AW(14), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_fcn(req_fcn), .req_typ(req_typ),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_misalign(resp_misalign),
        .mem_req(mem_req), .mem_gnt(gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [0:63];
    logic [31:0] rd0, rd1;

    always @(posedge clk) begin
        if (mem_req && gnt) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem[mem_addr[5:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                rd0 <= mem[mem_addr[5:0]];
            end
        end
        rd1 <= rd0;
    end
    assign mem_rdata = rd1;

    task automatic do_req(input t_m fcn, input t_mt typ, input logic [31:0] addr,
                          input logic [31:0] data, input int gnt_delay);
        lat = -1; rd = '0; mis = 1'b0; mreq_n = 0; unst = 1'b0; extra = 1'b0;
        be0 = '0; wd0 = '0; ad0 = '0; we0 = 1'b0;
        @(negedge clk);
        req_fcn = fcn; req_typ = typ; req_addr = addr; req_data = data; req_valid = 1'b1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (mem_req) begin
                mreq_n++;
                if (mreq_n == 1) begin
                    be0 = mem_be; wd0 = mem_wdata; ad0 = mem_addr; we0 = mem_we;
                end else if (be0 !== mem_be || wd0 !== mem_wdata || ad0 !== mem_addr || we0 !== mem_we) begin
                    unst = 1'b1;
                end
                gnt = (mreq_n > gnt_delay);
            end else begin
                gnt = 1'b0;
            end
            if (resp_valid) begin
                lat = n + 1; rd = resp_data; mis = resp_misalign; req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        extra = resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; gnt = 1'b0;
        req_addr = '0; req_data = '0; req_fcn = M_X; req_typ = MT_X;
        repeat (3) @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
        n_vec++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL rst_resp_data: got %h exp 0", resp_data); end
        n_vec++; if (resp_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b exp 0", resp_misalign); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
        n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b exp 0", mem_we); end
        n_vec++; if (mem_be !== 4'h0) begin n_err++; $display("FAIL rst_mem_be: got %b exp 0", mem_be); end
        n_vec++; if (mem_addr !== 14'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_store_byte();
        do_req(M_XWR, MT_B, 32'h103, 32'h0000_00AB, 0);
        n_vec++; if (be0 !== 4'b1000) begin n_err++; $display("FAIL sb_be: got %b exp 1000", be0); end
        n_vec++; if (wd0 !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_wdata: got %h exp ababab ab", wd0); end
        n_vec++; if (ad0 !== 14'h40) begin n_err++; $display("FAIL sb_addr: got %h exp 40", ad0); end
        n_vec++; if (we0 !== 1'b1) begin n_err++; $display("FAIL sb_we: got %b exp 1", we0); end
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL sb_latency: got %0d exp 3", lat); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL sb_resp_data: got %h exp 0", rd); end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("FAIL sb_single_pulse: got %b exp 0", extra); end
    endtask

    task automatic test_load_byte();
        do_req(M_XWR, MT_W, 32'h100, 32'h0080_0000, 0);
        n_vec++; if (be0 !== 4'b1111) begin n_err++; $display("FAIL sw_be: got %b exp 1111", be0); end
        do_req(M_XRD, MT_B, 32'h102, 32'h0, 0);
        n_vec++; if (rd !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h exp ffffff80", rd); end
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL lb_latency: got %0d exp 5", lat); end
        n_vec++; if (we0 !== 1'b0) begin n_err++; $display("FAIL lb_we: got %b exp 0", we0); end
        n_vec++; if (be0 !== 4'b0100) begin n_err++; $display("FAIL lb_be: got %b exp 0100", be0); end
        do_req(M_XRD, MT_BU, 32'h102, 32'h0, 0);
        n_vec++; if (rd !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_data: got %h exp 00000080", rd); end
    endtask

    task automatic test_half();
        do_req(M_XWR, MT_W, 32'h104, 32'h1111_2222, 0);
        do_req(M_XWR, MT_H, 32'h106, 32'h1234_ABCD, 0);
        n_vec++; if (be0 !== 4'b1100) begin n_err++; $display("FAIL sh_be: got %b exp 1100", be0); end
        n_vec++; if (wd0 !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata: got %h exp abcdabcd", wd0); end
        n_vec++; if (ad0 !== 14'h41) begin n_err++; $display("FAIL sh_addr: got %h exp 41", ad0); end
        do_req(M_XRD, MT_W, 32'h104, 32'h0, 0);
        n_vec++; if (rd !== 32'hABCD_2222) begin n_err++; $display("FAIL lw_merge: got %h exp abcd2222", rd); end
        do_req(M_XRD, MT_H, 32'h106, 32'h0, 0);
        n_vec++; if (rd !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL lh_data: got %h exp ffffabcd", rd); end
        do_req(M_XRD, MT_HU, 32'h106, 32'h0, 0);
        n_vec++; if (rd !== 32'h0000_ABCD) begin n_err++; $display("FAIL lhu_data: got %h exp 0000abcd", rd); end
        do_req(M_XRD, MT_H, 32'h104, 32'h0, 0);
        n_vec++; if (rd !== 32'h0000_2222) begin n_err++; $display("FAIL lh_low: got %h exp 00002222", rd); end
    endtask

    task automatic test_misalign();
        do_req(M_XRD, MT_H, 32'h1, 32'h0, 0);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL lh_mis_latency: got %0d exp 2", lat); end
        n_vec++; if (mis !== 1'b1) begin n_err++; $display("FAIL lh_mis_flag: got %b exp 1", mis); end
        n_vec++; if (mreq_n != 0) begin n_err++; $display("FAIL lh_mis_mem_req: got %0d exp 0", mreq_n); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL lh_mis_data: got %h exp 0", rd); end
        do_req(M_XRD, MT_W, 32'h102, 32'h0, 0);
        n_vec++; if (mis !== 1'b1 || mreq_n != 0) begin n_err++; $display("FAIL lw_mis: got mis=%b req=%0d exp 1/0", mis, mreq_n); end
        do_req(M_XWR, MT_WU, 32'h103, 32'h5555_5555, 0);
        n_vec++; if (mis !== 1'b1 || mreq_n != 0) begin n_err++; $display("FAIL sw_mis: got mis=%b req=%0d exp 1/0", mis, mreq_n); end
        do_req(M_XRD, MT_HU, 32'h102, 32'h0, 0);
        n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL lhu_aligned_flag: got %b exp 0", mis); end
    endtask

    task automatic test_stall();
        do_req(M_XWR, MT_W, 32'h108, 32'hDEAD_BEEF, 5);
        n_vec++; if (mreq_n != 6) begin n_err++; $display("FAIL stall_req_cycles: got %0d exp 6", mreq_n); end
        n_vec++; if (unst !== 1'b0) begin n_err++; $display("FAIL stall_fields_stable: got %b exp 0", unst); end
        n_vec++; if (lat != 8) begin n_err++; $display("FAIL stall_latency: got %0d exp 8", lat); end
        n_vec++; if (extra !== 1'b0) begin n_err++; $display("FAIL stall_single_pulse: got %b exp 0", extra); end
        do_req(M_XRD, MT_W, 32'h108, 32'h0, 0);
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stall_readback: got %h exp deadbeef", rd); end
    endtask

    task automatic test_fence();
        do_req(M_X, MT_X, 32'h100, 32'h0, 0);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL fence_latency: got %0d exp 2", lat); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL fence_data: got %h exp 0", rd); end
        n_vec++; if (mreq_n != 0) begin n_err++; $display("FAIL fence_mem_req: got %0d exp 0", mreq_n); end
        n_vec++; if (mis !== 1'b0) begin n_err++; $display("FAIL fence_misalign: got %b exp 0", mis); end
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        pulses = 0;
        @(negedge clk);
        req_fcn = M_XRD; req_typ = MT_W; req_addr = 32'h108; req_valid = 1'b1;
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rstwait_mem_req: got %b exp 0", mem_req); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rstwait_resp_now: got %b exp 0", resp_valid); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rstwait_no_resp: got %0d exp 0", pulses); end
        do_req(M_XRD, MT_W, 32'h108, 32'h0, 0);
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rstwait_next_lw: got %h exp deadbeef", rd); end
        n_vec++; if (lat != 5) begin n_err++; $display("FAIL rstwait_next_latency: got %0d exp 5", lat); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_half();
        test_misalign();
        test_stall();
        test_fence();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
